// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates NUM_PORTS requesters onto one byte-wide RAM/IO bus, 1/2/4-byte little-endian transfers.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default build uses fixed priority (highest index wins).
module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic [2*NUM_PORTS-1:0]      re_i,
    input  logic [2*NUM_PORTS-1:0]      we_i,
    input  logic [NUM_PORTS-1:0]        rsign_i,
    input  logic [ADDR_W*NUM_PORTS-1:0] addr_i,
    input  logic [DATA_W*NUM_PORTS-1:0] wdata_i,
    output logic                        busy_o,
    output logic [NUM_PORTS-1:0]        grant_o,
    output logic [NUM_PORTS-1:0]        done_o,
    output logic [DATA_W-1:0]           data_o,
    input  logic [7:0]                  ram_data_i,
    output logic [7:0]                  ram_data_o,
    output logic [ADDR_W-1:0]           ram_addr_o,
    output logic                        ram_wr_o
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t              state;
    logic [1:0]          size;
    logic                sign;
    logic [2:0]          cnt;
    logic [DATA_W-1:0]   wbuf;
    logic [DATA_W-1:0]   rbuf;

    logic [2:0]          nbytes;
    logic [DATA_W-1:0]   rbuf_nxt;
    logic [7:0]          wbyte_nxt;

    logic                req_any;
    logic                take;
    logic [NUM_PORTS-1:0] win_oh;
    logic                win_wr;
    logic [1:0]          win_size;
    logic                win_sign;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

`ifdef MEM_ARBITER_RR_EN
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       win;
    int unsigned         best;
    int unsigned         dist;
`endif

    function automatic logic [31:0] extend(input logic [31:0] b, input logic [1:0] sz, input logic s);
        case (sz)
            2'b01:   extend = s ? {{24{b[7]}}, b[7:0]}   : {24'h0, b[7:0]};
            2'b10:   extend = s ? {{16{b[15]}}, b[15:0]} : {16'h0, b[15:0]};
            default: extend = b;
        endcase
    endfunction

    // Candidate selection: fixed priority keeps the last (highest) requester;
    // round-robin keeps the requester closest after the pointer.
    always_comb begin
        req_any   = 1'b0;
        take      = 1'b0;
        win_oh    = '0;
        win_wr    = 1'b0;
        win_size  = 2'b00;
        win_sign  = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
`ifdef MEM_ARBITER_RR_EN
        win       = '0;
        best      = NUM_PORTS;
        dist      = 0;
`endif
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            take = (re_i[2*i +: 2] != 2'b00) || (we_i[2*i +: 2] != 2'b00);
`ifdef MEM_ARBITER_RR_EN
            dist = (i + NUM_PORTS - 32'(ptr)) % NUM_PORTS;
            take = take && (dist < best);
            if (take) begin
                best = dist;
                win  = PW'(i);
            end
`endif
            if (take) begin
                req_any   = 1'b1;
                win_oh    = NUM_PORTS'(1) << i;
                win_wr    = (we_i[2*i +: 2] != 2'b00);
                win_size  = win_wr ? we_i[2*i +: 2] : re_i[2*i +: 2];
                win_sign  = rsign_i[i];
                win_addr  = addr_i[ADDR_W*i +: ADDR_W];
                win_wdata = wdata_i[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        case (size)
            2'b01:   nbytes = 3'd1;
            2'b10:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // Read byte k arrives two cycles after its address, i.e. while cnt == k+1.
    always_comb begin
        rbuf_nxt = rbuf;
        case (cnt)
            3'd1:    rbuf_nxt[7:0]   = ram_data_i;
            3'd2:    rbuf_nxt[15:8]  = ram_data_i;
            3'd3:    rbuf_nxt[23:16] = ram_data_i;
            3'd4:    rbuf_nxt[31:24] = ram_data_i;
            default: ;
        endcase
    end

    always_comb begin
        case (cnt)
            3'd0:    wbyte_nxt = wbuf[15:8];
            3'd1:    wbyte_nxt = wbuf[23:16];
            default: wbyte_nxt = wbuf[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            grant_o    <= '0;
            done_o     <= '0;
            data_o     <= '0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
            ram_wr_o   <= 1'b0;
            cnt        <= '0;
            size       <= '0;
            sign       <= 1'b0;
            wbuf       <= '0;
            rbuf       <= '0;
`ifdef MEM_ARBITER_RR_EN
            ptr        <= '0;
`endif
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    done_o   <= '0;
                    ram_wr_o <= 1'b0;
                    cnt      <= '0;
                    if (req_any) begin
                        grant_o    <= win_oh;
                        busy_o     <= 1'b1;
                        size       <= win_size;
                        sign       <= win_sign;
                        wbuf       <= win_wdata;
                        rbuf       <= '0;
                        ram_addr_o <= win_addr;
                        if (win_wr) begin
                            state      <= WRITE;
                            ram_wr_o   <= 1'b1;
                            ram_data_o <= win_wdata[7:0];
                        end else begin
                            state <= READ;
                        end
`ifdef MEM_ARBITER_RR_EN
                        ptr <= (win == PW'(NUM_PORTS - 1)) ? '0 : win + PW'(1);
`endif
                    end else begin
                        grant_o <= '0;
                    end
                end
                READ: begin
                    rbuf <= rbuf_nxt;
                    if (cnt < nbytes - 3'd1)
                        ram_addr_o <= ram_addr_o + ADDR_W'(1);
                    if (cnt == nbytes) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= grant_o;
                        data_o <= extend(rbuf_nxt, size, sign);
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                WRITE: begin
                    if (cnt == nbytes - 3'd1) begin
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        done_o   <= grant_o;
                        ram_wr_o <= 1'b0;
                    end else begin
                        cnt        <= cnt + 3'd1;
                        ram_addr_o <= ram_addr_o + ADDR_W'(1);
                        ram_data_o <= wbyte_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model with 2-cycle read, completion scoreboard keyed on cycle number.
module tb_mem_arbiter;

    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            rdy;
    logic [2*NP-1:0] re_i;
    logic [2*NP-1:0] we_i;
    logic [NP-1:0]   rsign_i;
    logic [32*NP-1:0] addr_i;
    logic [32*NP-1:0] wdata_i;
    logic            busy_o;
    logic [NP-1:0]   grant_o;
    logic [NP-1:0]   done_o;
    logic [31:0]     data_o;
    logic [7:0]      ram_data_i = 8'h00;
    logic [7:0]      ram_data_o;
    logic [31:0]     ram_addr_o;
    logic            ram_wr_o;

    typedef struct {
        int          port;
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        me;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic [7:0]  mem [0:4095];
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [31:0] ld_word = '0;

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .re_i(re_i), .we_i(we_i), .rsign_i(rsign_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .grant_o(grant_o), .done_o(done_o), .data_o(data_o),
        .ram_data_i(ram_data_i), .ram_data_o(ram_data_o), .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM freezes with rdy like the rest of the system
    always @(posedge clk) begin
        if (ld_en) begin
            for (int b = 0; b < 4; b++) mem[ld_addr + 12'(b)] <= ld_word[8*b +: 8];
        end else if (rdy && ram_wr_o) begin
            mem[ram_addr_o[11:0]] <= ram_data_o;
        end
        if (rdy) ram_data_i <= mem[ram_addr_o[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rdy && done_o != '0) begin
            if (sbq.size() == 0) begin
                check("done_unexpected", 32'(done_o), 32'd0);
            end else begin
                me = sbq.pop_front();
                check("done_port", 32'(done_o), 32'd1 << me.port);
                check("done_cycle", cyc, me.cyc);
                if (me.rd) check("read_data", data_o, me.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] w);
        ld_addr = a;
        ld_word = w;
        ld_en   = 1'b1;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic drive(input int p, input logic [1:0] re, input logic [1:0] we, input logic s,
                         input logic [31:0] a, input logic [31:0] d);
        re_i[2*p +: 2]     = re;
        we_i[2*p +: 2]     = we;
        rsign_i[p]         = s;
        addr_i[32*p +: 32] = a;
        wdata_i[32*p +: 32] = d;
    endtask

    task automatic drop(input int p);
        re_i[2*p +: 2] = 2'b00;
        we_i[2*p +: 2] = 2'b00;
    endtask

    task automatic push_exp(input int p, input bit rd, input logic [31:0] d, input int c);
        exp_t e;
        e.port = p;
        e.rd   = rd;
        e.data = d;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    // Request sampled at the end of the current cycle; completion expected n+2 (read) or n+1 (write) later.
    task automatic issue(input int p, input logic [1:0] re, input logic [1:0] we, input logic s,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] ed, input int stall);
        bit rd;
        logic [1:0] sz;
        int n;
        rd = (we == 2'b00);
        sz = rd ? re : we;
        n  = (sz == 2'b11) ? 4 : int'(sz);
        drive(p, re, we, s, a, d);
        push_exp(p, rd, ed, cyc + n + (rd ? 2 : 1) + stall);
    endtask

    task automatic wait_idle(input int maxc);
        int c;
        c = 0;
        while ((busy_o || sbq.size() != 0) && c < maxc) begin
            step();
            c++;
        end
        check("idle_timeout", 32'(c < maxc), 32'd1);
        if (c >= maxc) sbq.delete();
    endtask

    task automatic xfer(input int p, input logic [1:0] re, input logic [1:0] we, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] ed);
        issue(p, re, we, s, a, d, ed, 0);
        step();
        drop(p);
        wait_idle(40);
    endtask

    initial begin
        int q0, q1, p0;
        int order[4];
        logic [7:0] wb[2];

        rst = 1'b1; rdy = 1'b0;
        re_i = '0; we_i = '0; rsign_i = '0; addr_i = '0; wdata_i = '0;
        step();
        step();
        check("rst_busy",  32'(busy_o),     32'd0);
        check("rst_grant", 32'(grant_o),    32'd0);
        check("rst_done",  32'(done_o),     32'd0);
        check("rst_data",  data_o,          32'd0);
        check("rst_addr",  ram_addr_o,      32'd0);
        check("rst_wdat",  32'(ram_data_o), 32'd0);
        check("rst_wr",    32'(ram_wr_o),   32'd0);
        rdy = 1'b1;
        step();
        rst = 1'b0;
        step();

        // word read, address sweep cycles 1..4
        poke(12'h100, 32'h12345678);
        issue(0, 2'b11, 2'b00, 1'b0, 32'h100, 32'h0, 32'h12345678, 0);
        step();
        drop(0);
        check("t1_grant", 32'(grant_o), 32'h1);
        check("t1_busy",  32'(busy_o),  32'h1);
        check("t1_addr",  ram_addr_o,   32'h100);
        for (int k = 1; k < 4; k++) begin
            step();
            check("t1_addr", ram_addr_o, 32'h100 + 32'(k));
        end
        wait_idle(20);

        // half write across 0x1FF/0x200
        wb[0] = 8'hEF;
        wb[1] = 8'hBE;
        issue(1, 2'b00, 2'b10, 1'b0, 32'h1FF, 32'h0000BEEF, 32'h0, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            if (k == 0) drop(1);
            check("t2_grant", 32'(grant_o),    32'h2);
            check("t2_wr",    32'(ram_wr_o),   32'h1);
            check("t2_addr",  ram_addr_o,      32'h1FF + 32'(k));
            check("t2_wdat",  32'(ram_data_o), 32'(wb[k]));
        end
        step();
        check("t2_wr_end", 32'(ram_wr_o), 32'h0);
        wait_idle(20);
        check("t2_data_hold", data_o, 32'h12345678);
        xfer(0, 2'b10, 2'b00, 1'b0, 32'h1FF, 32'h0, 32'h0000BEEF);

        // extension
        poke(12'h300, 32'h00008000);
        xfer(0, 2'b01, 2'b00, 1'b1, 32'h301, 32'h0, 32'hFFFFFF80);
        xfer(0, 2'b01, 2'b00, 1'b0, 32'h301, 32'h0, 32'h00000080);
        xfer(0, 2'b10, 2'b00, 1'b1, 32'h300, 32'h0, 32'hFFFF8000);
        xfer(1, 2'b10, 2'b00, 1'b0, 32'h300, 32'h0, 32'h00008000);

        // address wrap at top of space
        poke(12'hFFC, 32'hAB000000);
        poke(12'h000, 32'h000000CD);
        issue(1, 2'b10, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0000CDAB, 0);
        step();
        drop(1);
        check("wrap_addr0", ram_addr_o, 32'hFFFFFFFF);
        step();
        check("wrap_addr1", ram_addr_o, 32'h00000000);
        wait_idle(20);

        // re and we together: write wins
        issue(0, 2'b11, 2'b01, 1'b0, 32'h500, 32'h0000005A, 32'h0, 0);
        step();
        drop(0);
        check("rw_wr",   32'(ram_wr_o),   32'h1);
        check("rw_wdat", 32'(ram_data_o), 32'h5A);
        wait_idle(20);
        xfer(0, 2'b01, 2'b00, 1'b1, 32'h500, 32'h0, 32'h0000005A);

        // rdy low for 3 cycles mid-read
        issue(0, 2'b11, 2'b00, 1'b0, 32'h100, 32'h0, 32'h12345678, 3);
        step();
        drop(0);
        step();
        check("stall_addr_pre", ram_addr_o, 32'h101);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_addr", ram_addr_o, 32'h101);
        end
        rdy = 1'b1;
        wait_idle(30);

        // reset mid-write: partial bytes persist, no completion
        poke(12'h400, 32'h11111111);
        drive(1, 2'b00, 2'b11, 1'b0, 32'h400, 32'hCAFEF00D);
        step();
        drop(1);
        check("rstw_wdat0", 32'(ram_data_o), 32'h0D);
        step();
        check("rstw_wdat1", 32'(ram_data_o), 32'hF0);
        rst = 1'b1;
        step();
        check("rstw_busy",  32'(busy_o),     32'd0);
        check("rstw_grant", 32'(grant_o),    32'd0);
        check("rstw_done",  32'(done_o),     32'd0);
        check("rstw_data",  data_o,          32'd0);
        check("rstw_addr",  ram_addr_o,      32'd0);
        check("rstw_wdat",  32'(ram_data_o), 32'd0);
        check("rstw_wr",    32'(ram_wr_o),   32'd0);
        rst = 1'b0;
        step();
        step();
        check("rstw_idle", 32'(busy_o), 32'd0);
        xfer(0, 2'b11, 2'b00, 1'b0, 32'h400, 32'h0, 32'h1111F00D);

        // reset wins over rdy low
        rdy = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst_rdy0_data", data_o, 32'd0);
        rst = 1'b0;
        rdy = 1'b1;
        step();

        // two held requesters, two transactions each
`ifdef MEM_ARBITER_RR_EN
        order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;
`else
        order[0] = 1; order[1] = 1; order[2] = 0; order[3] = 0;
`endif
        q0 = 2;
        q1 = 2;
        p0 = cyc;
        for (int k = 0; k < 4; k++) push_exp(order[k], 1'b0, 32'h0, p0 + 2 * (k + 1));
        drive(0, 2'b00, 2'b01, 1'b0, 32'h600, 32'h000000A0);
        drive(1, 2'b00, 2'b01, 1'b0, 32'h610, 32'h000000B1);
        for (int c = 0; c < 24 && (q0 + q1) > 0; c++) begin
            step();
            if (done_o[0]) begin
                q0--;
                if (q0 == 0) drop(0);
            end
            if (done_o[1]) begin
                q1--;
                if (q1 == 0) drop(1);
            end
        end
        drop(0);
        drop(1);
        check("arb_quota", 32'(q0 + q1), 32'd0);
        wait_idle(10);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
